handshake_pipe_full_patting: RTL
================================

HANDSHAKE_PIPE_FULL_PATTING -- requirements
Module: handshake_pipe_full_patting

Interface
REQ-001 SHALL have parameter DATA_W, default 32, payload width in bits.
REQ-002 SHALL have parameter CNT_W, default 16, width of the delivered-beat counter.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous discard of all buffered beats.
REQ-006 SHALL have port master_valid  input  1  upstream beat valid.
REQ-007 SHALL have port master_data  input  DATA_W  upstream payload.
REQ-008 SHALL have port master_ready  output  1  block can accept a beat; driven directly from a flop.
REQ-009 SHALL have port slave_valid  output  1  downstream beat valid; driven directly from a flop.
REQ-010 SHALL have port slave_data  output  DATA_W  downstream payload; driven directly from a flop.
REQ-011 SHALL have port slave_ready  input  1  downstream accepts beat.
REQ-012 SHALL have port occupancy  output  2  buffered beat count, 0..2.
REQ-013 SHALL have port beat_cnt  output  CNT_W  count of delivered beats.

Function
REQ-014 SHALL define in_fire = master_valid & master_ready and out_fire = slave_valid & slave_ready.
REQ-015 SHALL have no combinational path from any input to any output; both valid and ready paths SHALL be broken.
REQ-016 SHALL store beats in a main register (drives slave_data) and a skid register.
REQ-017 SHALL implement states EMPTY (occupancy 0), BUSY (1), FULL (2).
REQ-018 SHALL drive slave_valid = (state != EMPTY) and master_ready = (state != FULL), both registered.
REQ-019 EMPTY: in_fire -> BUSY, main <= master_data; otherwise stay EMPTY.
REQ-020 BUSY: in_fire & out_fire -> BUSY, main <= master_data.
REQ-021 BUSY: in_fire & !out_fire -> FULL, skid <= master_data.
REQ-022 BUSY: !in_fire & out_fire -> EMPTY; neither fire -> BUSY, main unchanged.
REQ-023 FULL: out_fire -> BUSY, main <= skid; otherwise stay FULL; in_fire is impossible in FULL.
REQ-024 Latency SHALL be exactly 1 cycle from in_fire to slave_valid with that data when EMPTY.
REQ-025 SHALL sustain one beat per cycle when slave_ready is held high.
REQ-026 SHALL deliver beats in acceptance order, each exactly once, with no loss or duplication.
REQ-027 While slave_valid=1 and slave_ready=0, slave_data SHALL remain stable.
REQ-028 beat_cnt SHALL increment by 1 on every out_fire and wrap from 2^CNT_W-1 to 0.
REQ-029 flush SHALL force state EMPTY next cycle and override all transitions.
REQ-030 An in_fire coinciding with flush SHALL be discarded.
REQ-031 An out_fire coinciding with flush SHALL count as delivered and increment beat_cnt.
REQ-032 flush SHALL NOT clear beat_cnt or the data registers.

Reset
REQ-033 rst_n low SHALL immediately force state EMPTY, slave_valid 0, master_ready 1, occupancy 0, beat_cnt 0, slave_data 0, skid 0.
REQ-034 Reset asserted mid-transfer SHALL discard all buffered beats; no beat SHALL be presented after release until a new in_fire.
REQ-035 master_ready SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-036 State encoding (EMPTY=2'd0, BUSY=2'd1, FULL=2'd2) SHALL reside in shared package handshake_pkg, alongside the ready-patting block's constants.
REQ-037 occupancy SHALL equal the state encoding directly.
REQ-038 A single sub-module hs_data_slot (enabled DATA_W register with async reset) SHALL be instantiated twice, for main and skid.

Verification
REQ-039 Stream: slave_ready=1, send 0x11,0x22,0x33 on consecutive cycles -> slave_data 0x11,0x22,0x33 on the next three cycles; beat_cnt=3.
REQ-040 Backpressure: slave_ready=0, send 0xA0,0xA1 -> occupancy=2, master_ready=0; then slave_ready=1 -> 0xA0 then 0xA1; occupancy returns to 0.
REQ-041 Stall stability: hold slave_ready=0 for 10 cycles with 0x5A held -> slave_data=0x5A and slave_valid=1 throughout.
REQ-042 Flush collision: FULL with 0x01,0x02, then flush=1 with master_valid=1 carrying 0x03 -> next cycle EMPTY; 0x03 is never output; beat_cnt unchanged.
REQ-043 Wrap: preload 65535 beats (CNT_W=16), deliver one more -> beat_cnt=0.
REQ-044 Reset in BUSY holding 0x77 -> slave_valid=0 immediately; after release, slave_valid stays 0 until a new beat arrives.

Source files
------------

// File: rtl/handshake_pkg.sv
// Shared constants for the ready/valid patting pipe: state encoding and
// occupancy width (occupancy is the state encoding itself).
package handshake_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [OCC_W-1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } hs_state_e;

endpackage

// File: rtl/hs_data_slot.sv
// One payload register with load enable; used for both the main and the
// skid slot of the patting pipe.
module hs_data_slot #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/handshake_pipe_full_patting.sv
// Two-entry ready/valid pipe stage with both valid and ready registered:
// a main slot drives the output and a skid slot absorbs the beat in flight.
module handshake_pipe_full_patting
    import handshake_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              master_valid,
    input  logic [DATA_W-1:0] master_data,
    output logic              master_ready,
    output logic              slave_valid,
    output logic [DATA_W-1:0] slave_data,
    input  logic              slave_ready,
    output logic [OCC_W-1:0]  occupancy,
    output logic [CNT_W-1:0]  beat_cnt
);

    hs_state_e         state;
    hs_state_e         state_nxt;
    logic              in_fire;
    logic              out_fire;
    logic              main_en;
    logic              skid_en;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_q;

    assign in_fire   = master_valid & master_ready;
    assign out_fire  = slave_valid & slave_ready;
    assign occupancy = state;

    always_comb begin
        state_nxt = state;
        main_en   = 1'b0;
        skid_en   = 1'b0;
        main_d    = master_data;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_nxt = BUSY;
                    main_en   = 1'b1;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    main_en = 1'b1;
                end else if (in_fire) begin
                    state_nxt = FULL;
                    skid_en   = 1'b1;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                // master_ready is low here, so only the drain side can move
                if (out_fire) begin
                    state_nxt = BUSY;
                    main_en   = 1'b1;
                    main_d    = skid_q;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // Flush wins over everything, but leaves the data slots untouched
        if (flush) begin
            state_nxt = EMPTY;
            main_en   = 1'b0;
            skid_en   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= EMPTY;
            slave_valid  <= 1'b0;
            master_ready <= 1'b1;
            beat_cnt     <= '0;
        end else begin
            state        <= state_nxt;
            slave_valid  <= (state_nxt != EMPTY);
            master_ready <= (state_nxt != FULL);
            if (out_fire) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end

    hs_data_slot #(.DATA_W(DATA_W)) u_main_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (main_en),
        .d     (main_d),
        .q     (slave_data)
    );

    hs_data_slot #(.DATA_W(DATA_W)) u_skid_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (skid_en),
        .d     (master_data),
        .q     (skid_q)
    );

endmodule
